// File: rtl/pixel_sink_framebuffer.sv
// Pixel write responder backed by a shadow framebuffer, with a raster readout stream.
// Define PIXEL_SINK_STATS_EN to add the saturating writeCount/dropCount ports.
module pixel_sink_framebuffer #(
  parameter int unsigned WIDTH       = 240,
  parameter int unsigned HEIGHT      = 320,
  parameter int unsigned BUSY_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  input  logic        scanStart,
  output logic        scanBusy,
  output logic        scanValid,
  input  logic        scanReady,
  output logic [15:0] scanData,
  output logic [7:0]  scanX,
  output logic [8:0]  scanY
`ifdef PIXEL_SINK_STATS_EN
  ,
  output logic [15:0] writeCount,
  output logic [15:0] dropCount
`endif
);

  localparam int unsigned Depth = WIDTH * HEIGHT;
  localparam int unsigned AddrW = $clog2(Depth);

  typedef enum logic [1:0] {WInit, WIdle, WBusy} wr_state_e;
  typedef enum logic [1:0] {SIdle, SRead, SPresent} scan_state_e;

  logic [15:0] mem [Depth];

  wr_state_e        wr_state;
  logic [3:0]       busy_cnt;
  logic             wr_pend;
  logic             wr_in_range;
  logic [AddrW-1:0] wr_addr;
  logic [15:0]      wr_data;

  logic             in_range;
  logic [AddrW-1:0] acc_addr;

  scan_state_e      scan_state;
  logic [AddrW-1:0] scan_addr;
  logic             last_x;
  logic             last_y;

  assign in_range  = (32'(xAddr) < WIDTH) && (32'(yAddr) < HEIGHT);
  assign acc_addr  = AddrW'(32'(yAddr) * WIDTH + 32'(xAddr));
  assign scan_addr = AddrW'(32'(scanY) * WIDTH + 32'(scanX));
  assign last_x    = (32'(scanX) == WIDTH - 1);
  assign last_y    = (32'(scanY) == HEIGHT - 1);

  // Counter is loaded with BUSY_CYCLES-1 so pixelReady stays low for BUSY_CYCLES cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state    <= WInit;
      pixelReady  <= 1'b0;
      busy_cnt    <= '0;
      wr_pend     <= 1'b0;
      wr_in_range <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      wr_pend <= 1'b0;
      case (wr_state)
        WInit: begin
          wr_state   <= WIdle;
          pixelReady <= 1'b1;
        end
        WIdle: begin
          if (pixelWrite) begin
            wr_state    <= WBusy;
            pixelReady  <= 1'b0;
            busy_cnt    <= 4'(BUSY_CYCLES - 1);
            wr_pend     <= 1'b1;
            wr_in_range <= in_range;
            wr_addr     <= acc_addr;
            wr_data     <= pixelData;
          end
        end
        WBusy: begin
          if (busy_cnt == 4'd0) begin
            wr_state   <= WIdle;
            pixelReady <= 1'b1;
          end else begin
            busy_cnt <= busy_cnt - 4'd1;
          end
        end
        default: begin
          wr_state   <= WInit;
          pixelReady <= 1'b0;
        end
      endcase
    end
  end

  // Contents are deliberately not reset; the write lands one edge after accept.
  always_ff @(posedge clock) begin
    if (wr_pend && wr_in_range) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_state <= SIdle;
      scanBusy   <= 1'b0;
      scanValid  <= 1'b0;
      scanData   <= '0;
      scanX      <= '0;
      scanY      <= '0;
    end else begin
      case (scan_state)
        SIdle: begin
          if (scanStart) begin
            scanX      <= '0;
            scanY      <= '0;
            scanBusy   <= 1'b1;
            scan_state <= SRead;
          end
        end
        SRead: begin
          // Same-edge write is not visible here: the read returns the old word.
          scanData   <= mem[scan_addr];
          scanValid  <= 1'b1;
          scan_state <= SPresent;
        end
        SPresent: begin
          if (scanReady) begin
            scanValid <= 1'b0;
            if (last_x && last_y) begin
              scanBusy   <= 1'b0;
              scan_state <= SIdle;
            end else if (last_x) begin
              scanX      <= '0;
              scanY      <= scanY + 9'd1;
              scan_state <= SRead;
            end else begin
              scanX      <= scanX + 8'd1;
              scan_state <= SRead;
            end
          end
        end
        default: begin
          scan_state <= SIdle;
          scanBusy   <= 1'b0;
          scanValid  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIXEL_SINK_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      writeCount <= '0;
      dropCount  <= '0;
    end else if (wr_pend) begin
      if (wr_in_range) begin
        if (writeCount != 16'hFFFF) writeCount <= writeCount + 16'd1;
      end else begin
        if (dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_sink_framebuffer.sv
// Randomized bench for pixel_sink_framebuffer on a small frame, checked every cycle
// against a behavioural frame/stream model, plus literal expectations.
module tb_pixel_sink_framebuffer;

  localparam int W = 16;
  localparam int H = 24;
  localparam int B = 2;
  localparam int N = W * H;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  xAddr = '0;
  logic [8:0]  yAddr = '0;
  logic [15:0] pixelData = '0;
  logic        pixelWrite = 1'b0;
  logic        pixelReady;
  logic        scanStart = 1'b0;
  logic        scanBusy;
  logic        scanValid;
  logic        scanReady = 1'b0;
  logic [15:0] scanData;
  logic [7:0]  scanX;
  logic [8:0]  scanY;
  logic [15:0] writeCount;
  logic [15:0] dropCount;

  pixel_sink_framebuffer #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .BUSY_CYCLES(B)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .xAddr     (xAddr),
    .yAddr     (yAddr),
    .pixelData (pixelData),
    .pixelWrite(pixelWrite),
    .pixelReady(pixelReady),
    .scanStart (scanStart),
    .scanBusy  (scanBusy),
    .scanValid (scanValid),
    .scanReady (scanReady),
    .scanData  (scanData),
    .scanX     (scanX),
    .scanY     (scanY)
`ifdef PIXEL_SINK_STATS_EN
    ,
    .writeCount(writeCount),
    .dropCount (dropCount)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Model: frame contents, write-side readiness and the expected readout stream.
  logic [15:0] mm [N];
  bit          m_ready = 0;
  bit          m_init = 1;
  int          m_low = 0;
  bit          w_pend = 0;
  bit          w_inr = 0;
  int          w_addr = 0;
  logic [15:0] w_data = '0;
  int          m_wr = 0;
  int          m_dr = 0;
  int          sc_phase = 0;  // 0 idle, 1 awaiting read, 2 presenting
  int          sc_beat = 0;
  logic [15:0] sc_data = '0;

  int          n_acc = 0;
  int          n_hs = 0;
  logic [31:0] cap_f800 = '0;
  logic [31:0] cap_05 = '0;
  logic [31:0] cap_30 = '0;

  always @(negedge clock) begin
    if (reset) begin
      check("rst_pixelReady", 32'(pixelReady), 0);
      check("rst_scanBusy", 32'(scanBusy), 0);
      check("rst_scanValid", 32'(scanValid), 0);
      check("rst_scanData", 32'(scanData), 0);
      check("rst_scanXY", {15'd0, scanY, scanX}, 0);
`ifdef PIXEL_SINK_STATS_EN
      check("rst_counts", {writeCount, dropCount}, 0);
`endif
      m_ready = 0; m_init = 1; m_low = 0; w_pend = 0;
      m_wr = 0; m_dr = 0; sc_phase = 0; sc_beat = 0; sc_data = '0;
    end else begin
      check("pixelReady", 32'(pixelReady), 32'(m_ready));
      check("scanBusy", 32'(scanBusy), 32'(sc_phase != 0));
      check("scanValid", 32'(scanValid), 32'(sc_phase == 2));
      if (sc_phase == 2) begin
        check("scanX", 32'(scanX), sc_beat % W);
        check("scanY", 32'(scanY), sc_beat / W);
        check("scanData", 32'(scanData), 32'(sc_data));
      end
`ifdef PIXEL_SINK_STATS_EN
      if (m_ready && !w_pend) begin
        check("writeCount", 32'(writeCount), m_wr);
        check("dropCount", 32'(dropCount), m_dr);
      end
`endif
      if (pixelWrite && pixelReady) n_acc++;
      if (scanValid && scanReady) begin
        n_hs++;
        if (scanX == 8'd10 && scanY == 9'd20) cap_f800 = 32'(scanData);
        if (scanX == 8'd0 && scanY == 9'd5) cap_05 = 32'(scanData);
        if (scanX == 8'd3 && scanY == 9'd0) cap_30 = 32'(scanData);
      end
      // Predict the next edge: scan read sees the frame before this edge's write.
      case (sc_phase)
        0: if (scanStart) begin sc_phase = 1; sc_beat = 0; end
        1: begin sc_data = mm[sc_beat]; sc_phase = 2; end
        default: if (scanReady) begin
          if (sc_beat == N - 1) sc_phase = 0;
          else begin sc_beat++; sc_phase = 1; end
        end
      endcase
      if (w_pend) begin
        if (w_inr) begin
          mm[w_addr] = w_data;
          if (m_wr < 65535) m_wr++;
        end else if (m_dr < 65535) m_dr++;
        w_pend = 0;
      end
      if (m_init) begin
        m_init = 0; m_ready = 1;
      end else if (m_ready) begin
        if (pixelWrite) begin
          w_pend = 1;
          w_inr = (int'(xAddr) < W) && (int'(yAddr) < H);
          w_addr = int'(yAddr) * W + int'(xAddr);
          w_data = pixelData;
          m_ready = 0; m_low = B;
        end
      end else begin
        m_low--;
        if (m_low == 0) m_ready = 1;
      end
    end
  end

  task automatic write_pixel(input int x, input int y, input logic [15:0] d);
    int t = 0;
    xAddr = 8'(x); yAddr = 9'(y); pixelData = d; pixelWrite = 1'b1;
    while (!pixelReady && t < 50) begin tick; t++; end
    if (t >= 50) check("write_timeout", 1, 0);
    tick;
    pixelWrite = 1'b0;
  endtask

  task automatic rand_writes(input int count);
    for (int i = 0; i < count; i++) begin
      int x, y;
      repeat ($urandom_range(0, 3)) tick;
      x = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(0, W + 2);
      y = $urandom_range(0, H + 2);
      if ((x == 10 && y == 20) || (x == 0 && y == 5) || (x == 3 && y == 0)) y = H + 1;
      write_pixel(x, y, 16'($urandom));
    end
  endtask

  // mode 0: scanReady toggles every 3 cycles and a second scanStart lands mid-scan.
  task automatic run_scan(input int mode);
    int base = n_hs;
    int k = 0;
    bit done = 0;
    scanStart = 1'b1;
    tick;
    scanStart = 1'b0;
    while (!done && k < 40 * N) begin
      if (mode == 0) scanReady = ((k / 3) % 2) == 1;
      else scanReady = 1'($urandom_range(0, 1));
      scanStart = (mode == 0 && k == 50);
      tick;
      if (!scanBusy) done = 1;
      k++;
    end
    scanStart = 1'b0;
    scanReady = 1'b0;
    if (!done) check("scan_timeout", 1, 0);
    check("scan_beats", n_hs - base, N);
  endtask

  initial begin
    int lo, acc0, base, t;
    repeat (3) tick;
    reset = 1'b0;
    check("ready_after_release", 32'(pixelReady), 0);
    tick;
    check("ready_one_cycle_later", 32'(pixelReady), 1);
    check("busy_after_release", 32'(scanBusy), 0);

    for (int a = 0; a < N; a++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if (a == 5 * W) d = 16'h1234;
      if (a == 3) d = 16'h5678;
      write_pixel(a % W, a / W, d);
    end
    tick;

    reset = 1'b1;
    repeat (2) tick;
    reset = 1'b0;
    repeat (2) tick;

    write_pixel(240, 5, 16'hAAAA);
    write_pixel(3, 320, 16'h5555);
    while (!pixelReady) tick;
`ifdef PIXEL_SINK_STATS_EN
    check("drop_count_lit", 32'(dropCount), 2);
    check("write_count_lit", 32'(writeCount), 0);
`endif

    write_pixel(10, 20, 16'hF800);
    lo = 0;
    while (!pixelReady && lo < 20) begin tick; lo++; end
    check("ready_low_cycles", lo, 2);

    acc0 = n_acc;
    xAddr = 8'd10; yAddr = 9'd20; pixelData = 16'hF800; pixelWrite = 1'b1;
    t = 0;
    while (!pixelReady && t < 20) begin tick; t++; end
    tick;
    while (!pixelReady && t < 40) begin tick; t++; end
    tick;
    pixelWrite = 1'b0;
    check("double_accept", n_acc - acc0, 2);

    cap_f800 = '0; cap_05 = '0; cap_30 = '0;
    fork
      run_scan(0);
      rand_writes(60);
    join
    check("beat_10_20", cap_f800, 32'h0000_F800);
    check("beat_0_5", cap_05, 32'h0000_1234);
    check("beat_3_0", cap_30, 32'h0000_5678);

    base = n_hs;
    scanStart = 1'b1;
    tick;
    scanStart = 1'b0;
    t = 0;
    while (n_hs - base < 100 && t < 2000) begin
      scanReady = 1'($urandom_range(0, 1));
      tick;
      t++;
    end
    check("reach_beat_100", n_hs - base, 100);
    reset = 1'b1;
    #1;
    check("midreset_valid", 32'(scanValid), 0);
    check("midreset_busy", 32'(scanBusy), 0);
    scanReady = 1'b0;
    repeat (2) tick;
    reset = 1'b0;
    repeat (2) tick;

    scanStart = 1'b1;
    tick;
    scanStart = 1'b0;
    t = 0;
    while (!scanValid && t < 10) begin tick; t++; end
    check("restart_x", 32'(scanX), 0);
    check("restart_y", 32'(scanY), 0);
    t = 0;
    while (scanBusy && t < 40 * N) begin
      scanReady = 1'($urandom_range(0, 1));
      tick;
      t++;
    end
    scanReady = 1'b0;
    check("restart_done", 32'(scanBusy), 0);

    fork
      run_scan(1);
      rand_writes(40);
    join
    repeat (4) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
